// File: rtl/pong_match_controller.sv
// Pong match sequencer: synchronises the goal and restart inputs, and owns the scores,
// serve/pause timing, ball freeze, winner flag and buzzer for the score display.
module pong_match_controller #(
  parameter int WIN_SCORE       = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SERVE_DELAY     = 50000000,
  parameter int PAUSE_CYCLES    = 25000000,
  parameter int BUZZ_CYCLES     = 10000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_goal_player_1,
  input  logic       i_goal_player_2,
  input  logic       i_restart_game_btn,
  output logic [3:0] o_score_player_1,
  output logic [3:0] o_score_player_2,
  output logic       o_freeze_ball,
  output logic       o_serve,
  output logic       o_serve_dir,
  output logic [1:0] o_winner,
  output logic       o_buzzer
);

  localparam int TIMER_MAX = (SERVE_DELAY > PAUSE_CYCLES) ? SERVE_DELAY : PAUSE_CYCLES;
  localparam int TW = $clog2(TIMER_MAX + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(2 * BUZZ_CYCLES + 1);
  localparam logic [TW-1:0] SERVE_LAST = TW'(SERVE_DELAY - 1);
  localparam logic [TW-1:0] PAUSE_LAST = TW'(PAUSE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BUZZ_GOAL  = BW'(BUZZ_CYCLES);
  localparam logic [BW-1:0] BUZZ_OVER  = BW'(2 * BUZZ_CYCLES);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, GOAL, OVER} state_t;
  state_t state, state_next;

  logic goal1_p0, goal1_p1, goal1_p2;
  logic goal2_p0, goal2_p1, goal2_p2;
  logic btn_p0, btn_p1;
  logic goal1_edge, goal2_edge;
  logic [DW-1:0] deb_cnt;
  logic deb_level, deb_prev, press;
  logic [TW-1:0] timer;
  logic [BW-1:0] buzz_cnt;
  logic clear_all, inc1, inc2, timer_run, serve_next, buzz_goal, buzz_over;
  logic win1, win2;

  // Synchroniser stage: p0/p1 are the 2-FF sync, p2 holds the previous synced sample
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      goal1_p0 <= 1'b0; goal1_p1 <= 1'b0; goal1_p2 <= 1'b0;
      goal2_p0 <= 1'b0; goal2_p1 <= 1'b0; goal2_p2 <= 1'b0;
      btn_p0   <= 1'b0; btn_p1   <= 1'b0;
    end else begin
      goal1_p0 <= i_goal_player_1; goal1_p1 <= goal1_p0; goal1_p2 <= goal1_p1;
      goal2_p0 <= i_goal_player_2; goal2_p1 <= goal2_p0; goal2_p2 <= goal2_p1;
      btn_p0   <= i_restart_game_btn; btn_p1 <= btn_p0;
    end
  end

  assign goal1_edge = goal1_p1 & ~goal1_p2;
  assign goal2_edge = goal2_p1 & ~goal2_p2;

  // Debounce stage: any sample agreeing with the current level restarts the count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
    end else begin
      deb_prev <= deb_level;
      if (btn_p1 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_level <= btn_p1;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign press = deb_level & ~deb_prev;
  assign win1  = (o_score_player_1 + 4'd1) == WIN;
  assign win2  = (o_score_player_2 + 4'd1) == WIN;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // A press overrides everything, so goal edges in that cycle are dropped
  always_comb begin
    state_next = state;
    clear_all  = 1'b0;
    inc1       = 1'b0;
    inc2       = 1'b0;
    timer_run  = 1'b0;
    serve_next = 1'b0;
    buzz_goal  = 1'b0;
    buzz_over  = 1'b0;
    if (press) begin
      clear_all  = 1'b1;
      state_next = SERVE;
    end else begin
      case (state)
        IDLE: ;
        SERVE: begin
          if (timer == SERVE_LAST) begin
            state_next = PLAY;
            serve_next = 1'b1;
          end else begin
            timer_run = 1'b1;
          end
        end
        PLAY: begin
          if (goal1_edge) begin
            inc1       = 1'b1;
            state_next = win1 ? OVER : GOAL;
            buzz_over  = win1;
            buzz_goal  = ~win1;
          end else if (goal2_edge) begin
            inc2       = 1'b1;
            state_next = win2 ? OVER : GOAL;
            buzz_over  = win2;
            buzz_goal  = ~win2;
          end
        end
        GOAL: begin
          if (timer == PAUSE_LAST) state_next = SERVE;
          else                     timer_run  = 1'b1;
        end
        OVER: ;
        default: state_next = IDLE;
      endcase
    end
  end

  // Match-state stage: timer, scores, serve pulse, winner and buzzer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer            <= '0;
      o_score_player_1 <= 4'd0;
      o_score_player_2 <= 4'd0;
      o_serve          <= 1'b0;
      o_serve_dir      <= 1'b0;
      o_winner         <= 2'b00;
      buzz_cnt         <= '0;
    end else begin
      timer   <= timer_run ? timer + 1'b1 : '0;
      o_serve <= serve_next;
      if (clear_all) begin
        o_score_player_1 <= 4'd0;
        o_score_player_2 <= 4'd0;
        o_winner         <= 2'b00;
        o_serve_dir      <= 1'b0;
      end else if (inc1) begin
        o_score_player_1 <= o_score_player_1 + 4'd1;
        o_serve_dir      <= 1'b1;
        if (win1) o_winner <= 2'b01;
      end else if (inc2) begin
        o_score_player_2 <= o_score_player_2 + 4'd1;
        o_serve_dir      <= 1'b0;
        if (win2) o_winner <= 2'b10;
      end
      if (clear_all)          buzz_cnt <= '0;
      else if (buzz_over)     buzz_cnt <= BUZZ_OVER;
      else if (buzz_goal)     buzz_cnt <= BUZZ_GOAL;
      else if (buzz_cnt != 0) buzz_cnt <= buzz_cnt - 1'b1;
    end
  end

  assign o_freeze_ball = (state != PLAY);
  assign o_buzzer      = (buzz_cnt == '0);

endmodule
